mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
// Byte-serial memory controller between the cpu core caches and the external 8-bit RAM/IO bus.
// Accepts 32-bit instruction fetches from icache and 1/2/4-byte loads and stores from dcache.
// Arbitrates the two requesters and serialises each access into single-byte bus cycles.
// Sole driver of mem_a, mem_dout and mem_wr.
// PARAMETERS
// IO_STALL_EN  1  when 1, stores to IO space (addr[17:16]==2'b11) wait while io_buffer_full is high
// PORTS
// clk_in          in   1   system clock
// rst_n_in        in   1   reset; asynchronous, active-low
// rdy_in          in   1   global ready; when low, all state is frozen
// flush_in        in   1   misprediction flush; aborts speculative reads
// if_req_in       in   1   icache word-fetch request; level, held until if_done_out
// if_addr_in      in   32  fetch address
// if_done_out     out  1   one-cycle pulse; if_data_out is valid
// if_data_out     out  32  fetched word, little-endian
// d_req_in        in   1   dcache request; level, held until d_done_out
// d_wr_in         in   1   1 = store, 0 = load
// d_size_in       in   2   00 = byte, 01 = half, 10 = word (11 is treated as word)
// d_addr_in       in   32  data address
// d_wdata_in      in   32  store data; low bytes are used
// d_done_out      out  1   one-cycle pulse; load data is valid or the store is complete
// d_rdata_out     out  32  load data, zero-extended (sign extension is done by slb)
// mem_din         in   8   RAM read byte; valid the cycle after its address is presented
// io_buffer_full  in   1   UART buffer full
// mem_dout        out  8   write byte
// mem_a           out  32  byte address
// mem_wr          out  1   1 = write
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, counters 0.
// - FSM states:
//   - IDLE: no bus activity, so mem_wr=0 and mem_a=0.
//   - READ: N+1 cycles for N bytes.
//   - WRITE: N cycles for N bytes.
// - Accepting a request in IDLE:
//   - A request is accepted only when if_done_out=0 and d_done_out=0.
//   - If both requests are present, d_req_in wins. An accepted access is never preempted.
//   - On accept, the controller latches the address, size (fetch = 4 bytes) and wdata, and clears issue_idx/capture_idx.
// - READ:
//   - Each cycle, mem_a = base + issue_idx while issue_idx < N.
//   - The byte on mem_din is stored into byte lane capture_idx during the cycle after its address was issued.
//   - After the last capture, the matching done pulse is asserted for exactly one cycle with the data registered, and the FSM returns to IDLE.
//   - Latency: word read done is asserted at cycle accept+5. Byte read done is asserted at accept+2.
// - WRITE:
//   - Each cycle: mem_wr=1, mem_a = base + idx, mem_dout = wdata byte idx.
//   - d_done_out is asserted the cycle after the last byte, then the FSM returns to IDLE.
// - IO stall (stores only): if IO_STALL_EN, the address is in IO space and io_buffer_full=1, then mem_wr=0 and idx holds until io_buffer_full is low.
// - rdy_in low:
//   - State, counters and outputs hold, and mem_wr is forced to 0.
//   - A byte issued in the cycle before rdy_in fell is discarded. Its address is re-presented when rdy_in returns high.
// - flush_in high:
//   - Aborts any instruction fetch and any data load to non-IO space. The FSM goes to IDLE next cycle and no done pulse is given.
//   - Stores and IO-space loads are never aborted, because IO reads are destructive.
//   - A flush while in IDLE has no effect. A flush in the same cycle as an accept cancels that accept.
// - Address wrap: base+idx is computed at 32-bit width, with no carry beyond bit 31.
// - Reset asserted mid-access: the controller returns to IDLE immediately (asynchronously) and mem_wr drops to 0 the same cycle.
// TESTING
// - Word fetch at 0x100; RAM returns 13,00,01,02 -> if_data_out=0x02010013; if_done_out high exactly at accept+5, for 1 cycle.
// - Same-cycle if_req_in and d_req_in (LB at 0x2000) -> data served first; fetch starts the cycle after d_done_out and the request is dropped.
// - SW 0x41424344 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr low for 3 cycles, then 44,43,42,41 written; d_done_out follows.
// - flush_in at fetch capture_idx=2 -> no if_done_out, IDLE next cycle; a concurrent store still completes all bytes.
// - rdy_in low 2 cycles during word load -> d_rdata_out identical to the unstalled case; mem_wr stays 0 throughout.
// - rst_n_in pulsed low mid-SH -> mem_wr=0 asynchronously; no d_done_out; next request is accepted normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates icache fetches and dcache loads/stores
// onto the 8-bit RAM/IO bus, one byte per cycle.
module mem_ctrl #(
  parameter bit IO_STALL_EN = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        d_req_in,
  input  logic        d_wr_in,
  input  logic [1:0]  d_size_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  output logic        d_done_out,
  output logic [31:0] d_rdata_out,
  input  logic [7:0]  mem_din,
  input  logic        io_buffer_full,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d, wdata_q, wdata_d, data_q, data_d;
  logic [2:0]  size_q, size_d, issue_q, issue_d, cap_q, cap_d;
  logic        is_if_q, is_if_d, if_done_q, if_done_d, d_done_q, d_done_d;
  logic        io_space, d_io, stall;
  logic [2:0]  d_nbytes;

  always_comb begin
    case (d_size_in)
      2'b00:   d_nbytes = 3'd1;
      2'b01:   d_nbytes = 3'd2;
      default: d_nbytes = 3'd4;
    endcase
    io_space = (base_q[17:16] == 2'b11);
    d_io     = (d_addr_in[17:16] == 2'b11);
    stall    = IO_STALL_EN && io_space && io_buffer_full;

    state_d   = state_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    size_d    = size_q;
    issue_d   = issue_q;
    cap_d     = cap_q;
    is_if_d   = is_if_q;
    if_done_d = if_done_q;
    d_done_d  = d_done_q;

    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state_q)
      READ: if (issue_q < size_q) mem_a = base_q + {29'd0, issue_q};
      WRITE: begin
        mem_a    = base_q + {29'd0, issue_q};
        mem_dout = wdata_q[{issue_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy_in && !stall;
      end
      default: ;
    endcase

    if (!rdy_in) begin
      // a read byte in flight while stalled is lost; rewind so it is re-issued
      if (state_q == READ) issue_d = cap_q;
    end else begin
      if_done_d = 1'b0;
      d_done_d  = 1'b0;
      case (state_q)
        IDLE: if (!if_done_q && !d_done_q) begin
          if (d_req_in) begin
            if (!(flush_in && !d_wr_in && !d_io)) begin
              base_d  = d_addr_in;
              size_d  = d_nbytes;
              wdata_d = d_wdata_in;
              data_d  = '0;
              is_if_d = 1'b0;
              issue_d = '0;
              cap_d   = '0;
              state_d = d_wr_in ? WRITE : READ;
            end
          end else if (if_req_in && !flush_in) begin
            base_d  = if_addr_in;
            size_d  = 3'd4;
            data_d  = '0;
            is_if_d = 1'b1;
            issue_d = '0;
            cap_d   = '0;
            state_d = READ;
          end
        end
        READ: begin
          // IO reads are destructive, so only fetches and RAM loads may be aborted
          if (flush_in && (is_if_q || !io_space)) begin
            state_d = IDLE;
          end else begin
            if (issue_q < size_q) issue_d = issue_q + 3'd1;
            if (cap_q < issue_q) begin
              data_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
              cap_d = cap_q + 3'd1;
              if (cap_q + 3'd1 == size_q) begin
                state_d   = IDLE;
                if_done_d = is_if_q;
                d_done_d  = !is_if_q;
              end
            end
          end
        end
        WRITE: if (!stall) begin
          issue_d = issue_q + 3'd1;
          if (issue_q + 3'd1 == size_q) begin
            state_d  = IDLE;
            d_done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      base_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      size_q    <= '0;
      issue_q   <= '0;
      cap_q     <= '0;
      is_if_q   <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      size_q    <= size_d;
      issue_q   <= issue_d;
      cap_q     <= cap_d;
      is_if_q   <= is_if_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
    end
  end

  assign if_done_out = if_done_q;
  assign d_done_out  = d_done_q;
  assign if_data_out = data_q;
  assign d_rdata_out = data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model answering one cycle after each address.
module tb_mem_ctrl;
  logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
  logic        if_req_in = 1'b0, d_req_in = 1'b0, d_wr_in = 1'b0, io_buffer_full = 1'b0;
  logic [31:0] if_addr_in = '0, d_addr_in = '0, d_wdata_in = '0;
  logic [1:0]  d_size_in = '0;
  logic [7:0]  mem_din = '0;
  logic        if_done_out, d_done_out, mem_wr;
  logic [31:0] if_data_out, d_rdata_out, mem_a;
  logic [7:0]  mem_dout;

  logic [7:0]  ram [0:65535];
  int          wr_cnt = 0, if_cnt = 0;
  logic [7:0]  last_wr = '0;
  int          vectors = 0, miscompares = 0;

  mem_ctrl #(.IO_STALL_EN(1'b1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
    .if_data_out(if_data_out), .d_req_in(d_req_in), .d_wr_in(d_wr_in),
    .d_size_in(d_size_in), .d_addr_in(d_addr_in), .d_wdata_in(d_wdata_in),
    .d_done_out(d_done_out), .d_rdata_out(d_rdata_out), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wr <= mem_dout;
    end
    if (if_done_out) if_cnt <= if_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_d(input int max, output int lat);
    lat = 0;
    while (!d_done_out && lat < max) begin step(); lat++; end
    chk("d_done_seen", {31'd0, d_done_out}, 32'd1);
  endtask

  task automatic wait_if(input int max, output int lat);
    lat = 0;
    while (!if_done_out && lat < max) begin step(); lat++; end
    chk("if_done_seen", {31'd0, if_done_out}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, w0, i0;
    logic [31:0] word;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h00; ram[16'h0102] = 8'h01; ram[16'h0103] = 8'h02;
    ram[16'h2000] = 8'hA5;
    ram[16'h0400] = 8'h11; ram[16'h0401] = 8'h22; ram[16'h0402] = 8'h33; ram[16'h0403] = 8'h44;

    // reset state
    step(); step();
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_if_done", {31'd0, if_done_out}, 32'd0);
    chk("rst_d_done", {31'd0, d_done_out}, 32'd0);
    chk("rst_d_rdata", d_rdata_out, 32'd0);
    rst_n_in = 1'b1;
    step();

    // word fetch: done exactly at accept+5, one cycle
    if_req_in = 1'b1; if_addr_in = 32'h100;
    step();
    chk("fetch_first_addr", mem_a, 32'h100);
    wait_if(8, lat);
    chk("fetch_latency", lat, 32'd5);
    chk("fetch_data", if_data_out, 32'h02010013);
    if_req_in = 1'b0;
    step();
    chk("fetch_done_pulse", {31'd0, if_done_out}, 32'd0);

    // simultaneous requests: load byte wins, fetch follows
    if_req_in = 1'b1; if_addr_in = 32'h100;
    d_req_in = 1'b1; d_wr_in = 1'b0; d_size_in = 2'b00; d_addr_in = 32'h2000;
    step();
    wait_d(6, lat);
    chk("lb_latency", lat, 32'd2);
    chk("lb_data", d_rdata_out, 32'h000000A5);
    chk("lb_no_if_done", {31'd0, if_done_out}, 32'd0);
    d_req_in = 1'b0;
    step();
    chk("arb_idle_gap", mem_a, 32'd0);
    step();
    chk("arb_fetch_start", mem_a, 32'h100);
    wait_if(8, lat);
    chk("arb_fetch_latency", lat, 32'd5);
    chk("arb_fetch_data", if_data_out, 32'h02010013);
    if_req_in = 1'b0;
    step();

    // IO store stalled by full UART buffer for 3 cycles
    w0 = wr_cnt;
    word = 32'h41424344;
    d_req_in = 1'b1; d_wr_in = 1'b1; d_size_in = 2'b10; d_addr_in = 32'h30000;
    d_wdata_in = word; io_buffer_full = 1'b1;
    step();
    chk("io_stall_c1", {31'd0, mem_wr}, 32'd0);
    step();
    chk("io_stall_c2", {31'd0, mem_wr}, 32'd0);
    step();
    chk("io_stall_c3", {31'd0, mem_wr}, 32'd0);
    io_buffer_full = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("io_wr", {31'd0, mem_wr}, 32'd1);
      chk("io_addr", mem_a, 32'h30000 + i);
      chk("io_byte", {24'd0, mem_dout}, {24'd0, word[8*i +: 8]});
      step();
    end
    chk("io_st_done", {31'd0, d_done_out}, 32'd1);
    chk("io_wr_count", wr_cnt - w0, 32'd4);
    d_req_in = 1'b0;
    step();

    // flush during fetch at capture_idx=2; store raised alongside completes
    i0 = if_cnt;
    if_req_in = 1'b1; if_addr_in = 32'h100;
    step(); step(); step(); step();
    flush_in = 1'b1; if_req_in = 1'b0;
    d_req_in = 1'b1; d_wr_in = 1'b1; d_size_in = 2'b10; d_addr_in = 32'h500; d_wdata_in = 32'hDDCCBBAA;
    w0 = wr_cnt;
    step();
    flush_in = 1'b0;
    chk("flush_idle_addr", mem_a, 32'd0);
    chk("flush_no_if_done", {31'd0, if_done_out}, 32'd0);
    wait_d(8, lat);
    chk("flush_st_bytes", wr_cnt - w0, 32'd4);
    chk("flush_st_last", {24'd0, last_wr}, 32'h000000DD);
    chk("flush_if_pulses", if_cnt - i0, 32'd0);
    d_req_in = 1'b0;
    step();

    // word load unstalled, then with rdy low for 2 cycles
    d_req_in = 1'b1; d_wr_in = 1'b0; d_size_in = 2'b10; d_addr_in = 32'h400;
    step();
    wait_d(10, lat);
    chk("lw_latency", lat, 32'd5);
    chk("lw_data", d_rdata_out, 32'h44332211);
    d_req_in = 1'b0;
    step();
    w0 = wr_cnt;
    d_req_in = 1'b1;
    step(); step(); step();
    rdy_in = 1'b0;
    step();
    chk("rdy_low_wr", {31'd0, mem_wr}, 32'd0);
    step();
    rdy_in = 1'b1;
    wait_d(12, lat);
    chk("lw_stall_latency", lat, 32'd4);
    chk("lw_stall_data", d_rdata_out, 32'h44332211);
    chk("lw_stall_no_wr", wr_cnt - w0, 32'd0);
    d_req_in = 1'b0;
    step();

    // reset mid-SH
    w0 = wr_cnt;
    d_req_in = 1'b1; d_wr_in = 1'b1; d_size_in = 2'b01; d_addr_in = 32'h600; d_wdata_in = 32'h0000BEEF;
    step();
    chk("sh_wr_first", {31'd0, mem_wr}, 32'd1);
    chk("sh_byte0", {24'd0, mem_dout}, 32'h000000EF);
    #2 rst_n_in = 1'b0;
    #1;
    chk("rst_async_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_async_addr", mem_a, 32'd0);
    d_req_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    step();
    chk("rst_no_d_done", {31'd0, d_done_out}, 32'd0);
    chk("rst_sh_no_bytes", wr_cnt - w0, 32'd0);
    d_req_in = 1'b1; d_wr_in = 1'b0; d_size_in = 2'b00; d_addr_in = 32'h2000;
    step();
    wait_d(6, lat);
    chk("post_rst_lb_latency", lat, 32'd2);
    chk("post_rst_lb_data", d_rdata_out, 32'h000000A5);
    d_req_in = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
